threshold_applier: RTL

- Receiving end of the threshold-update interface driven by the button block (8-bit value plus a one-cycle valid strobe).
- Sanitises each update: undoes the +5/-5 wrap-around and clamps to a legal range. The accepted value is held in a shadow register and committed only at a frame boundary, so a frame never tears.
- Uses the active threshold to binarise the pixel stream in a 2-stage pipeline.
- Returns the latest accepted value to the button block's threshold_in, so repeated presses within one frame accumulate.

---
 rtl/threshold_applier_pkg.sv | 26 ++
 rtl/threshold_applier_if.sv | 32 +++
 rtl/threshold_applier_sanitiser.sv | 31 +++
 rtl/threshold_applier.sv | 112 +++++++++++
 4 files changed

// File: rtl/threshold_applier_pkg.sv
// Shared types and constants for the threshold update path and the pixel binariser.
// Imported by the interface, the sanitiser and the top level.
package threshold_applier_pkg;

    typedef logic [7:0] threshold_t;

    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } state_t;

    // Button block steps by THRESH_STEP; a jump larger than WRAP_LIMIT means its 8-bit counter wrapped.
    localparam int THRESH_STEP = 5;
    localparam int WRAP_LIMIT  = 128;

    function automatic threshold_t clamp_thresh(input threshold_t value,
                                                input threshold_t lo,
                                                input threshold_t hi);
        threshold_t result;
        result = value;
        if (value < lo) result = lo;
        if (value > hi) result = hi;
        return result;
    endfunction

endpackage

// File: rtl/threshold_applier_if.sv
// Update strobe, pixel stream and binarised output bundled between a source (master) and the applier (slave).
// Signal names match the block's port names so both sides read the same.
interface threshold_applier_if;
    import threshold_applier_pkg::*;

    threshold_t threshold_in;
    logic       threshold_valid_in;
    logic [7:0] pixel_in;
    logic       pixel_valid_in;
    logic       frame_start_in;

    threshold_t threshold_latest_out;
    threshold_t threshold_active_out;
    logic       threshold_pending_out;
    logic [7:0] update_count_out;
    logic       pixel_bit_out;
    logic       pixel_valid_out;
    logic       frame_start_out;

    modport master (
        output threshold_in, threshold_valid_in, pixel_in, pixel_valid_in, frame_start_in,
        input  threshold_latest_out, threshold_active_out, threshold_pending_out,
               update_count_out, pixel_bit_out, pixel_valid_out, frame_start_out
    );

    modport slave (
        input  threshold_in, threshold_valid_in, pixel_in, pixel_valid_in, frame_start_in,
        output threshold_latest_out, threshold_active_out, threshold_pending_out,
               update_count_out, pixel_bit_out, pixel_valid_out, frame_start_out
    );

endinterface

// File: rtl/threshold_applier_sanitiser.sv
// Combinational clean-up of a proposed threshold: undoes 8-bit wrap-around of the button
// counter relative to the current reference, then clamps into [MIN_THRESH, MAX_THRESH].
module threshold_sanitiser
    import threshold_applier_pkg::*;
#(
    parameter int MIN_THRESH = 5,
    parameter int MAX_THRESH = 250
) (
    input  threshold_t i_value,
    input  threshold_t i_ref,
    output threshold_t o_value
);

    localparam threshold_t MIN_T = threshold_t'(MIN_THRESH);
    localparam threshold_t MAX_T = threshold_t'(MAX_THRESH);

    logic signed [8:0] w_diff;

    assign w_diff = $signed({1'b0, i_value}) - $signed({1'b0, i_ref});

    always_comb begin
        o_value = clamp_thresh(i_value, MIN_T, MAX_T);
        // A huge negative jump is an increment that rolled past 255, and vice versa.
        if (w_diff < -WRAP_LIMIT) begin
            o_value = MAX_T;
        end else if (w_diff > WRAP_LIMIT) begin
            o_value = MIN_T;
        end
    end

endmodule

// File: rtl/threshold_applier.sv
// Applies sanitised threshold updates at frame boundaries (shadow/active pair) and
// binarises the pixel stream against the applied threshold in a 2-stage pipeline.
module threshold_applier
    import threshold_applier_pkg::*;
#(
    parameter int DEFAULT_THRESH = 128,
    parameter int MIN_THRESH     = 5,
    parameter int MAX_THRESH     = 250
) (
    input  logic                clk_in,
    input  logic                rst_in,
    threshold_applier_if.slave  bus
);

    localparam threshold_t DEFAULT_T = threshold_t'(DEFAULT_THRESH);

    state_t     r_state;
    threshold_t r_active;
    threshold_t r_shadow;
    logic [7:0] r_count;

    logic [7:0] r_s1_pixel;
    threshold_t r_s1_thr;
    logic       r_s1_valid;
    logic       r_s1_frame;
    logic       r_s2_bit;
    logic       r_s2_valid;
    logic       r_s2_frame;

    logic       w_pending;
    logic       w_frame_start;
    logic       w_commit;
    threshold_t w_ref;
    threshold_t w_sanitised;

    assign w_pending     = (r_state == PENDING);
    assign w_frame_start = bus.frame_start_in && bus.pixel_valid_in;
    assign w_commit      = w_frame_start && w_pending;
    assign w_ref         = w_pending ? r_shadow : r_active;

    threshold_sanitiser #(
        .MIN_THRESH (MIN_THRESH),
        .MAX_THRESH (MAX_THRESH)
    ) u_sanitiser (
        .i_value (bus.threshold_in),
        .i_ref   (w_ref),
        .o_value (w_sanitised)
    );

    // Update FSM: a strobe coinciding with a commit commits the old shadow and stays pending with the new one.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state  <= IDLE;
            r_active <= DEFAULT_T;
            r_shadow <= DEFAULT_T;
            r_count  <= 8'd0;
        end else begin
            if (w_commit) begin
                r_active <= r_shadow;
            end
            case (r_state)
                IDLE: begin
                    if (bus.threshold_valid_in) begin
                        r_state <= PENDING;
                    end
                end
                PENDING: begin
                    if (w_commit && !bus.threshold_valid_in) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
            if (bus.threshold_valid_in) begin
                r_shadow <= w_sanitised;
                if (r_count != 8'hFF) begin
                    r_count <= r_count + 8'd1;
                end
            end
        end
    end

    // The frame-start pixel that commits is already compared against the newly committed value.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_s1_pixel <= 8'd0;
            r_s1_thr   <= DEFAULT_T;
            r_s1_valid <= 1'b0;
            r_s1_frame <= 1'b0;
            r_s2_bit   <= 1'b0;
            r_s2_valid <= 1'b0;
            r_s2_frame <= 1'b0;
        end else begin
            r_s1_pixel <= bus.pixel_in;
            r_s1_thr   <= w_commit ? r_shadow : r_active;
            r_s1_valid <= bus.pixel_valid_in;
            r_s1_frame <= w_frame_start;
            r_s2_bit   <= r_s1_valid && (r_s1_pixel >= r_s1_thr);
            r_s2_valid <= r_s1_valid;
            r_s2_frame <= r_s1_frame;
        end
    end

    assign bus.threshold_latest_out  = w_ref;
    assign bus.threshold_active_out  = r_active;
    assign bus.threshold_pending_out = w_pending;
    assign bus.update_count_out      = r_count;
    assign bus.pixel_bit_out         = r_s2_bit;
    assign bus.pixel_valid_out       = r_s2_valid;
    assign bus.frame_start_out       = r_s2_frame;

endmodule
